// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Arbiter and sequencer for the single shared data-memory bus. Two requesters
// compete for the bus: the CPU M-stage load/store port and the DMA/debug port.
// One access is granted at a time, and its fields are held on the memory
// port until the memory acknowledges. The CPU normally wins. A pending DMA
// request that keeps losing is forced to win once it has lost DMA_WAIT_MAX
// arbitrations in a row.
//
// Ports
//   clk                         system clock, rising edge
//   reset                       asynchronous, active-low
//   c_req/c_byteen/c_addr/c_wdata  CPU access (byteen 0 = read)
//   c_rdata, c_stall            CPU read data and pipeline freeze
//   d_req/d_byteen/d_addr/d_wdata  DMA access, held until d_done
//   d_done, d_rdata             DMA completion pulse and read data
//   m_req/m_byteen/m_addr/m_wdata  registered memory request
//   m_ack, m_rdata              memory completion and read data
module dmem_arbiter #(
  parameter int unsigned DMA_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [3:0]  c_byteen,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic [3:0]  d_byteen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(DMA_WAIT_MAX);

  state_t      r_state;
  logic [3:0]  r_dma_wait;
  logic        r_m_req;
  logic [3:0]  r_m_byteen;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;

  logic        w_dma_forced;
  logic        w_grant_dma;
  logic        w_arb;

  assign w_dma_forced = (r_dma_wait == WAIT_MAX);
  // The DMA wins when it is alone, or when it has lost enough times in a row.
  assign w_grant_dma  = d_req & (~c_req | w_dma_forced);
  // An arbitration happens only on an edge that is in IDLE.
  assign w_arb        = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dma_wait <= 4'd0;
      r_m_req    <= 1'b0;
      r_m_byteen <= 4'd0;
      r_m_addr   <= 32'd0;
      r_m_wdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_dma) begin
            r_state    <= S_DMA;
            r_m_req    <= 1'b1;
            r_m_byteen <= d_byteen;
            r_m_addr   <= d_addr;
            r_m_wdata  <= d_wdata;
          end else if (c_req) begin
            r_state    <= S_CPU;
            r_m_req    <= 1'b1;
            r_m_byteen <= c_byteen;
            r_m_addr   <= c_addr;
            r_m_wdata  <= c_wdata;
          end
        end
        S_CPU, S_DMA: begin
          // The latched fields stay put after the ack. Only m_req drops.
          if (m_ack) begin
            r_state <= S_IDLE;
            r_m_req <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_m_req <= 1'b0;
        end
      endcase

      // The wait counter counts lost arbitrations, not bus cycles. It holds
      // its value while an access is in flight, so a CPU access with a long
      // latency still costs the DMA only one step.
      if (!d_req || (w_arb && w_grant_dma))
        r_dma_wait <= 4'd0;
      else if (w_arb && c_req && !w_dma_forced)
        r_dma_wait <= r_dma_wait + 4'd1;
    end
  end

  assign m_req    = r_m_req;
  assign m_byteen = r_m_byteen;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;

  // The stall is released in the ack cycle itself, so the CPU captures
  // c_rdata on the same edge that the arbiter returns to IDLE.
  assign c_stall  = c_req & ~((r_state == S_CPU) & m_ack);
  assign c_rdata  = m_rdata;
  assign d_done   = (r_state == S_DMA) & m_ack;
  assign d_rdata  = m_rdata;

endmodule
